code_patch_cfg_regs: RTL and testbench
======================================

Name: code_patch_cfg_regs

Overview:
- Wishbone classic slave register file that configures the code patch core's pattern address, data, enable and no-propagate controls.
- Software writes go to shadow registers. A commit request copies all shadows to the active outputs atomically, and only in a cycle where the patched CPU bus is idle. This prevents a patch from changing in the middle of a transaction.
- Sits between the configuration bus and the patch wrapper's cfg_*/ctl_* inputs.

Parameters:
- ADDR_WIDTH, 32, patched bus address width; must be ≤32.
- DATA_WIDTH, 16, patched bus data width.
- NUM_REGS, 2, number of patch slots; 1..8.
- SUB_REGS_DATA_WIDTH, (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH, width of the pattern data entry; must be ≤32.
- CFG_AW, 8, config bus address width (byte address).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cfg_dat_i  in  32  write data.
- cfg_adr_i  in  CFG_AW  byte address; bits [1:0] ignored.
- cfg_cyc_i  in  1  cycle.
- cfg_stb_i  in  1  strobe.
- cfg_we_i  in  1  write enable.
- cfg_sel_i  in  4  byte selects.
- cfg_dat_o  out  32  read data.
- cfg_ack_o  out  1  ack.
- cfg_err_o  out  1  error (unmapped address).
- bus_busy_i  in  1  patched bus cycle in progress (wb_si_cyc_i).
- cfg_pat_gen_o  out  1  active pattern-gen enable.
- cfg_addr_or_data_o  out  1  active mode.
- ctl_pat_addr_o  out  ADDR_WIDTH x NUM_REGS  active pattern addresses.
- ctl_pat_data_o  out  SUB_REGS_DATA_WIDTH x NUM_REGS  active pattern data.
- ctl_pat_pen_o  out  NUM_REGS  active per-slot enable.
- ctl_pat_nopg_o  out  NUM_REGS  active per-slot no-propagate.
- commit_pending_o  out  1  a commit is waiting for bus idle.
- commit_done_o  out  1  one-cycle pulse when active registers are updated.

Behaviour:
- Reset (async, rst_i=1): all outputs, shadows, active registers and the commit counter clear to 0. FSM goes to IDLE. A reset during PENDING abandons the commit.
- Register map (word offsets):
  - 0x00 CTRL: bit0 pat_gen, bit1 addr_or_data, bit30 CANCEL (write-1, reads 0), bit31 COMMIT (write-1, reads as pending).
  - 0x04 PEN.
  - 0x08 NOPG.
  - 0x0C STATUS (RO): bit0 pending, [15:8] commit count, 8-bit wrapping.
  - 0x10+8*i ADDR[i]; 0x14+8*i DATA[i], for i < NUM_REGS.
- Write/read width rules:
  - Writes honour cfg_sel_i per byte.
  - Bits above a field's width are discarded on write and read as 0.
  - Reads return shadow values, not active values.
- Handshake:
  - A request is accepted when cyc&stb&!ack&!err.
  - cfg_ack_o or cfg_err_o asserts for exactly one cycle on the following edge; cfg_dat_o is valid in that cycle, else 0.
  - Back-to-back requests are therefore serviced every 2 cycles.
  - The write takes effect on the acknowledging edge.
- Unmapped or RO targets:
  - An unmapped offset, or a slot index ≥ NUM_REGS, gives cfg_err_o instead of ack; no state changes.
  - A write to STATUS is acked and ignored.
- Commit FSM:
  - IDLE: a CTRL write with bit31=1 (byte 3 selected) goes to PENDING.
  - PENDING: commit_pending_o=1. If bus_busy_i=0 in this cycle, go to COMMIT. A CANCEL write goes to IDLE with no copy.
  - COMMIT: copy all shadows to active on this edge, pulse commit_done_o, increment the counter, go to IDLE.
  - COMMIT is one cycle; outputs change only on the COMMIT edge.
- Simultaneous events:
  - COMMIT and CANCEL written together: cancel wins, so the FSM stays in or returns to IDLE.
  - COMMIT written while PENDING: no effect.
  - Shadow write on the same edge as the COMMIT copy: the active registers take the pre-write shadow value; the new value needs another commit.
  - A CTRL write with bit31 also updates bits 0–1 of the shadow first; the commit then copies the updated value.
  - bus_busy_i held high: the FSM stays PENDING indefinitely; there is no timeout.
- Counter: 8-bit, wraps 255→0.

Test Plan:
- Reset mid-PENDING (rst_i pulse while bus_busy_i=1) -> all outputs 0, commit_pending_o=0, STATUS=0.
- Write ADDR[0]=0x0000_1000, DATA[0]=0xBEEF, PEN=1, CTRL=0x8000_0001 with bus_busy_i=0 -> ack 1 cycle after each strobe; commit_done_o pulses 2 cycles after the CTRL ack edge; ctl_pat_addr_o[0]=0x1000, ctl_pat_data_o[0]=0xBEEF, pen=1, pat_gen=1; STATUS[15:8]=1.
- COMMIT with bus_busy_i=1 for 10 cycles -> outputs unchanged and commit_pending_o=1 throughout; copy happens on the edge after bus_busy_i falls.
- While PENDING, write CTRL=0x4000_0000 -> pending clears, outputs unchanged, counter unchanged; write 0xC000_0000 -> no commit.
- Read offset 0x20 with NUM_REGS=2, and read 0x7C -> cfg_err_o one cycle, cfg_ack_o=0, no state change; byte write sel=0x2 data 0x0000_AB00 to ADDR[1] -> readback 0x0000_AB00.
- 256 commits -> counter wraps to 0; commit_done_o count equals 256.

Source files
------------

// File: rtl/code_patch_cfg_regs.sv
// Wishbone classic configuration registers for the code patch core.
// Software writes land in shadow registers; a commit copies them to the active outputs only while the patched bus is idle.
module code_patch_cfg_regs #(
    parameter int ADDR_WIDTH          = 32,
    parameter int DATA_WIDTH          = 16,
    parameter int NUM_REGS            = 2,
    parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
    parameter int CFG_AW              = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [31:0]                             cfg_dat_i,
    input  logic [CFG_AW-1:0]                       cfg_adr_i,
    input  logic                                    cfg_cyc_i,
    input  logic                                    cfg_stb_i,
    input  logic                                    cfg_we_i,
    input  logic [3:0]                              cfg_sel_i,
    output logic [31:0]                             cfg_dat_o,
    output logic                                    cfg_ack_o,
    output logic                                    cfg_err_o,
    input  logic                                    bus_busy_i,
    output logic                                    cfg_pat_gen_o,
    output logic                                    cfg_addr_or_data_o,
    output logic [ADDR_WIDTH*NUM_REGS-1:0]          ctl_pat_addr_o,
    output logic [SUB_REGS_DATA_WIDTH*NUM_REGS-1:0] ctl_pat_data_o,
    output logic [NUM_REGS-1:0]                     ctl_pat_pen_o,
    output logic [NUM_REGS-1:0]                     ctl_pat_nopg_o,
    output logic                                    commit_pending_o,
    output logic                                    commit_done_o
);

    localparam int IDX_W = CFG_AW - 2;
    localparam int unused_data_width = DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_COMMIT
    } state_t;

    state_t state_q, state_d;

    logic                           sh_pat_gen, sh_addr_or_data;
    logic [NUM_REGS-1:0]            sh_pen, sh_nopg;
    logic [ADDR_WIDTH-1:0]          sh_addr [NUM_REGS];
    logic [SUB_REGS_DATA_WIDTH-1:0] sh_data [NUM_REGS];
    logic [ADDR_WIDTH-1:0]          act_addr [NUM_REGS];
    logic [SUB_REGS_DATA_WIDTH-1:0] act_data [NUM_REGS];
    logic [7:0]                     commit_cnt;

    logic [IDX_W-1:0] word, slot;
    logic             sel_ctrl, sel_pen, sel_nopg, sel_status, slot_hit, is_data, mapped;
    logic             req, wr_en, ctrl_wr, commit_req, cancel_req;
    logic [31:0]      rd_val, wr_val;
    logic             unused_adr_lsb;

    assign unused_adr_lsb = ^cfg_adr_i[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wdat,
                                                input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = wdat[8*b +: 8];
        end
        return r;
    endfunction

    // Word decode: slots start at word 4 and alternate ADDR/DATA.
    assign word       = cfg_adr_i[CFG_AW-1:2];
    assign slot       = (word - IDX_W'(4)) >> 1;
    assign is_data    = word[0];
    assign sel_ctrl   = (word == IDX_W'(0));
    assign sel_pen    = (word == IDX_W'(1));
    assign sel_nopg   = (word == IDX_W'(2));
    assign sel_status = (word == IDX_W'(3));
    assign slot_hit   = (word >= IDX_W'(4)) && (slot < IDX_W'(NUM_REGS));
    assign mapped     = sel_ctrl || sel_pen || sel_nopg || sel_status || slot_hit;

    assign req        = cfg_cyc_i && cfg_stb_i && !cfg_ack_o && !cfg_err_o;
    assign wr_en      = req && mapped && cfg_we_i;
    assign ctrl_wr    = wr_en && sel_ctrl && cfg_sel_i[3];
    assign commit_req = ctrl_wr && cfg_dat_i[31];
    assign cancel_req = ctrl_wr && cfg_dat_i[30];

    assign commit_pending_o = (state_q == S_PENDING);

    // NOTE: rd_val gets a full default before any conditional update, so no latch can be inferred.
    always_comb begin
        rd_val = '0;
        if (sel_ctrl) begin
            rd_val[0]  = sh_pat_gen;
            rd_val[1]  = sh_addr_or_data;
            rd_val[31] = commit_pending_o;
        end
        if (sel_pen)  rd_val[NUM_REGS-1:0] = sh_pen;
        if (sel_nopg) rd_val[NUM_REGS-1:0] = sh_nopg;
        if (sel_status) begin
            rd_val[0]    = commit_pending_o;
            rd_val[15:8] = commit_cnt;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (slot_hit && slot == IDX_W'(i)) begin
                if (is_data) rd_val[SUB_REGS_DATA_WIDTH-1:0] = sh_data[i];
                else         rd_val[ADDR_WIDTH-1:0]          = sh_addr[i];
            end
        end
    end

    // The zero-extended current value doubles as the base for byte-lane merging.
    assign wr_val = merge_bytes(rd_val, cfg_dat_i, cfg_sel_i);

    // NOTE: every flop, including the slot arrays, takes the async reset so the patch core
    // never sees an unknown configuration; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_ack_o       <= 1'b0;
            cfg_err_o       <= 1'b0;
            cfg_dat_o       <= '0;
            sh_pat_gen      <= 1'b0;
            sh_addr_or_data <= 1'b0;
            sh_pen          <= '0;
            sh_nopg         <= '0;
            sh_addr         <= '{default: '0};
            sh_data         <= '{default: '0};
        end else begin
            cfg_ack_o <= req && mapped;
            cfg_err_o <= req && !mapped;
            cfg_dat_o <= (req && mapped && !cfg_we_i) ? rd_val : '0;
            if (wr_en) begin
                if (sel_ctrl) begin
                    sh_pat_gen      <= wr_val[0];
                    sh_addr_or_data <= wr_val[1];
                end
                if (sel_pen)  sh_pen  <= wr_val[NUM_REGS-1:0];
                if (sel_nopg) sh_nopg <= wr_val[NUM_REGS-1:0];
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (slot_hit && slot == IDX_W'(i)) begin
                        if (is_data) sh_data[i] <= wr_val[SUB_REGS_DATA_WIDTH-1:0];
                        else         sh_addr[i] <= wr_val[ADDR_WIDTH-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Cancel outranks both a fresh commit request and a bus-idle cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (commit_req && !cancel_req) state_d = S_PENDING;
            S_PENDING: begin
                if (cancel_req)       state_d = S_IDLE;
                else if (!bus_busy_i) state_d = S_COMMIT;
            end
            S_COMMIT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Copy happens on the edge that leaves COMMIT, so a shadow write on that same edge is not captured.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_pat_gen_o      <= 1'b0;
            cfg_addr_or_data_o <= 1'b0;
            ctl_pat_pen_o      <= '0;
            ctl_pat_nopg_o     <= '0;
            act_addr           <= '{default: '0};
            act_data           <= '{default: '0};
            commit_cnt         <= '0;
            commit_done_o      <= 1'b0;
        end else begin
            commit_done_o <= (state_q == S_COMMIT);
            if (state_q == S_COMMIT) begin
                cfg_pat_gen_o      <= sh_pat_gen;
                cfg_addr_or_data_o <= sh_addr_or_data;
                ctl_pat_pen_o      <= sh_pen;
                ctl_pat_nopg_o     <= sh_nopg;
                act_addr           <= sh_addr;
                act_data           <= sh_data;
                commit_cnt         <= commit_cnt + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign ctl_pat_addr_o[g*ADDR_WIDTH +: ADDR_WIDTH]                   = act_addr[g];
        assign ctl_pat_data_o[g*SUB_REGS_DATA_WIDTH +: SUB_REGS_DATA_WIDTH] = act_data[g];
    end

endmodule

// File: tb/tb_code_patch_cfg_regs.sv
// Scoreboard bench for code_patch_cfg_regs: bus responses are checked by a monitor against a queue,
// active outputs and commit timing are checked directly.
module tb_code_patch_cfg_regs;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] cfg_dat_i;
    logic [7:0]  cfg_adr_i;
    logic        cfg_cyc_i, cfg_stb_i, cfg_we_i;
    logic [3:0]  cfg_sel_i;
    logic [31:0] cfg_dat_o;
    logic        cfg_ack_o, cfg_err_o;
    logic        bus_busy_i;
    logic        cfg_pat_gen_o, cfg_addr_or_data_o;
    logic [63:0] ctl_pat_addr_o;
    logic [63:0] ctl_pat_data_o;
    logic [1:0]  ctl_pat_pen_o, ctl_pat_nopg_o;
    logic        commit_pending_o, commit_done_o;

    code_patch_cfg_regs dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .cfg_dat_i          (cfg_dat_i),
        .cfg_adr_i          (cfg_adr_i),
        .cfg_cyc_i          (cfg_cyc_i),
        .cfg_stb_i          (cfg_stb_i),
        .cfg_we_i           (cfg_we_i),
        .cfg_sel_i          (cfg_sel_i),
        .cfg_dat_o          (cfg_dat_o),
        .cfg_ack_o          (cfg_ack_o),
        .cfg_err_o          (cfg_err_o),
        .bus_busy_i         (bus_busy_i),
        .cfg_pat_gen_o      (cfg_pat_gen_o),
        .cfg_addr_or_data_o (cfg_addr_or_data_o),
        .ctl_pat_addr_o     (ctl_pat_addr_o),
        .ctl_pat_data_o     (ctl_pat_data_o),
        .ctl_pat_pen_o      (ctl_pat_pen_o),
        .ctl_pat_nopg_o     (ctl_pat_nopg_o),
        .commit_pending_o   (commit_pending_o),
        .commit_done_o      (commit_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          err;
        logic [31:0] dat;
        logic [7:0]  adr;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response cycle must match the oldest outstanding request.
    always @(negedge clk_i) begin
        rsp_t e;
        if (commit_done_o) done_cnt++;
        if (cfg_ack_o || cfg_err_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: ack %0b err %0b with no request outstanding", cfg_ack_o, cfg_err_o);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rsp_err@%02h", e.adr), 64'(cfg_err_o), 64'(e.err));
                check($sformatf("rsp_ack@%02h", e.adr), 64'(cfg_ack_o), 64'(!e.err));
                check($sformatf("rsp_dat@%02h", e.adr), 64'(cfg_dat_o), 64'(e.dat));
            end
        end
    end

    task automatic wb(input bit we, input logic [7:0] adr, input logic [31:0] d, input logic [3:0] sel,
                      input bit exp_err, input logic [31:0] exp_dat);
        rsp_t e;
        @(negedge clk_i);
        while (cfg_ack_o || cfg_err_o) @(negedge clk_i);
        e.err = exp_err;
        e.dat = exp_dat;
        e.adr = adr;
        exp_q.push_back(e);
        cfg_cyc_i = 1'b1;
        cfg_stb_i = 1'b1;
        cfg_we_i  = we;
        cfg_adr_i = adr;
        cfg_dat_i = d;
        cfg_sel_i = sel;
        @(posedge clk_i);
        #1;
        check($sformatf("rsp_latency@%02h", adr), 64'(cfg_ack_o | cfg_err_o), 64'd1);
        cfg_cyc_i = 1'b0;
        cfg_stb_i = 1'b0;
        cfg_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] adr, input logic [31:0] d, input logic [3:0] sel);
        wb(1'b1, adr, d, sel, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [7:0] adr, input logic [31:0] exp);
        wb(1'b0, adr, 32'h0, 4'hF, 1'b0, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_i = 1'b1;
        #2 rst_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_ref;
        rst_i = 1'b1; bus_busy_i = 1'b1;
        cfg_cyc_i = 1'b0; cfg_stb_i = 1'b0; cfg_we_i = 1'b0;
        cfg_adr_i = '0; cfg_dat_i = '0; cfg_sel_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        check("reset_addr", ctl_pat_addr_o, 64'h0);
        check("reset_ack", 64'(cfg_ack_o), 64'h0);
        check("reset_pending", 64'(commit_pending_o), 64'h0);

        // Reset during PENDING abandons the commit and clears shadows.
        wr(8'h10, 32'h0000_1234, 4'hF);
        wr(8'h00, 32'h8000_0000, 4'h8);
        check("pending_before_reset", 64'(commit_pending_o), 64'h1);
        repeat (2) tick();
        pulse_reset();
        check("rst_mid_pending", 64'(commit_pending_o), 64'h0);
        check("rst_mid_addr", ctl_pat_addr_o, 64'h0);
        check("rst_mid_done", 64'(commit_done_o), 64'h0);
        rd(8'h0C, 32'h0000_0000);
        rd(8'h10, 32'h0000_0000);

        // Basic commit with idle bus.
        bus_busy_i = 1'b0;
        wr(8'h10, 32'h0000_1000, 4'hF);
        wr(8'h14, 32'h0000_BEEF, 4'hF);
        wr(8'h04, 32'h0000_0001, 4'hF);
        wr(8'h00, 32'h8000_0001, 4'hF);
        check("c1_pending", 64'(commit_pending_o), 64'h1);
        tick();
        check("c1_done_early", 64'(commit_done_o), 64'h0);
        check("c1_patgen_early", 64'(cfg_pat_gen_o), 64'h0);
        tick();
        check("c1_done", 64'(commit_done_o), 64'h1);
        check("c1_addr", ctl_pat_addr_o, 64'h0000_0000_0000_1000);
        check("c1_data", ctl_pat_data_o, 64'h0000_0000_0000_BEEF);
        check("c1_pen", 64'(ctl_pat_pen_o), 64'h1);
        check("c1_patgen", 64'(cfg_pat_gen_o), 64'h1);
        rd(8'h0C, 32'h0000_0100);
        rd(8'h00, 32'h0000_0001);
        rd(8'h14, 32'h0000_BEEF);

        // Shadow write on the copy edge is not captured by that commit.
        wr(8'h1C, 32'h0000_1111, 4'hF);
        wr(8'h00, 32'h8000_0001, 4'hF);
        wr(8'h1C, 32'h0000_2222, 4'hF);
        check("same_edge_done", 64'(commit_done_o), 64'h1);
        check("same_edge_data", ctl_pat_data_o, 64'h0000_1111_0000_BEEF);
        rd(8'h1C, 32'h0000_2222);

        // Commit held off by a busy bus.
        bus_busy_i = 1'b1;
        wr(8'h10, 32'h0000_2000, 4'hF);
        wr(8'h00, 32'h8000_0003, 4'hF);
        rd(8'h00, 32'h8000_0003);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("busy_pending_%0d", i), 64'(commit_pending_o), 64'h1);
            check($sformatf("busy_addr_%0d", i), ctl_pat_addr_o, 64'h0000_0000_0000_1000);
        end
        bus_busy_i = 1'b0;
        tick();
        check("busy_rel_pending", 64'(commit_pending_o), 64'h0);
        check("busy_rel_addr", ctl_pat_addr_o, 64'h0000_0000_0000_1000);
        tick();
        check("busy_commit_done", 64'(commit_done_o), 64'h1);
        check("busy_commit_addr", ctl_pat_addr_o, 64'h0000_0000_0000_2000);
        check("busy_commit_aod", 64'(cfg_addr_or_data_o), 64'h1);
        check("busy_commit_data", ctl_pat_data_o, 64'h0000_2222_0000_BEEF);
        rd(8'h0C, 32'h0000_0300);

        // Cancel while pending, then commit+cancel together.
        bus_busy_i = 1'b1;
        wr(8'h10, 32'h0000_3000, 4'hF);
        wr(8'h00, 32'h8000_0001, 4'hF);
        check("cancel_pending_set", 64'(commit_pending_o), 64'h1);
        wr(8'h00, 32'h4000_0000, 4'hF);
        check("cancel_pending_clr", 64'(commit_pending_o), 64'h0);
        done_ref = done_cnt;
        bus_busy_i = 1'b0;
        repeat (4) tick();
        check("cancel_addr", ctl_pat_addr_o, 64'h0000_0000_0000_2000);
        check("cancel_patgen", 64'(cfg_pat_gen_o), 64'h1);
        check("cancel_done_cnt", 64'(done_cnt), 64'(done_ref));
        rd(8'h0C, 32'h0000_0300);
        wr(8'h00, 32'hC000_0000, 4'hF);
        check("both_pending", 64'(commit_pending_o), 64'h0);
        repeat (4) tick();
        check("both_addr", ctl_pat_addr_o, 64'h0000_0000_0000_2000);
        check("both_done_cnt", 64'(done_cnt), 64'(done_ref));
        rd(8'h0C, 32'h0000_0300);
        rd(8'h00, 32'h0000_0000);

        // Unmapped accesses, read-only STATUS, byte lanes and field widths.
        wb(1'b0, 8'h20, 32'h0, 4'hF, 1'b1, 32'h0);
        wb(1'b0, 8'h7C, 32'h0, 4'hF, 1'b1, 32'h0);
        wb(1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
        wr(8'h0C, 32'hFFFF_FFFF, 4'hF);
        rd(8'h0C, 32'h0000_0300);
        rd(8'h10, 32'h0000_3000);
        check("err_no_pending", 64'(commit_pending_o), 64'h0);
        wr(8'h18, 32'h0000_AB00, 4'h2);
        rd(8'h18, 32'h0000_AB00);
        wr(8'h10, 32'hFFFF_FF55, 4'h1);
        rd(8'h10, 32'h0000_3055);
        wr(8'h04, 32'hFFFF_FFFF, 4'hF);
        rd(8'h04, 32'h0000_0003);
        wr(8'h08, 32'hFFFF_FFFF, 4'hE);
        rd(8'h08, 32'h0000_0000);

        // Counter wrap over 256 commits from reset.
        repeat (2) tick();
        pulse_reset();
        rd(8'h0C, 32'h0000_0000);
        done_ref = done_cnt;
        for (int i = 0; i < 256; i++) begin
            wr(8'h00, 32'h8000_0000, 4'h8);
            repeat (3) tick();
            if (i == 254) rd(8'h0C, 32'h0000_FF00);
        end
        rd(8'h0C, 32'h0000_0000);
        check("wrap_done_count", 64'(done_cnt - done_ref), 64'd256);

        repeat (2) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
